// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one byte-wide, combinationally read memory between an
//            instruction-fetch port and a data-load port. Each granted
//            request reads four consecutive bytes starting at the request
//            address and assembles them big-endian into a 32-bit word. When
//            both ports request in the same idle cycle, the arbiter picks
//            them in round-robin order.
// Ports    : i_clk, i_rst_n         clock, asynchronous active-low reset
//            i_if_req/i_if_addr     fetch request and byte address
//            o_if_ack/o_if_instr    fetch completion pulse and word
//            i_ld_req/i_ld_addr     load request and byte address
//            o_ld_ack/o_ld_data     load completion pulse and word
//            o_mem_addr/i_mem_rdata shared memory byte address and read data
//            o_busy                 a transaction is in progress
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ack,
    output logic [31:0] o_if_instr,
    input  logic        i_ld_req,
    input  logic [31:0] i_ld_addr,
    output logic        o_ld_ack,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_mem_addr,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_busy
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_READ     = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;

    localparam logic       c_OWNER_IF = 1'b0;
    localparam logic       c_OWNER_LD = 1'b1;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [1:0]  r_beat;
    logic [31:0] r_base;
    // Port of the current transaction. It keeps its value after the
    // transaction ends, so it also tells the arbiter which port was granted
    // last.
    logic        r_owner;
    // Bytes from beats 0..2. The beat-3 byte goes straight into the result
    // register, so the finished word is ready in the cycle after beat 3.
    logic [23:0] r_asm;
    logic [31:0] r_if_instr;
    logic [31:0] r_ld_data;

    logic        w_grant_valid;
    logic        w_grant_owner;
    logic [31:0] w_word;

    // If both ports request at once, grant the port that was not granted last.
    assign w_grant_valid = i_if_req | i_ld_req;
    assign w_grant_owner = (i_if_req && i_ld_req) ? ~r_owner
                         : (i_ld_req ? c_OWNER_LD : c_OWNER_IF);
    assign w_word        = {r_asm, i_mem_rdata};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= c_IDLE;
            r_beat     <= 2'd0;
            r_base     <= 32'd0;
            r_owner    <= c_OWNER_IF;
            r_asm      <= 24'd0;
            r_if_instr <= 32'd0;
            r_ld_data  <= 32'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant_owner;
                        r_base  <= (w_grant_owner == c_OWNER_LD) ? i_ld_addr : i_if_addr;
                        r_beat  <= 2'd0;
                    end
                end
                c_READ: begin
                    case (r_beat)
                        2'd0:    r_asm[23:16] <= i_mem_rdata;
                        2'd1:    r_asm[15:8]  <= i_mem_rdata;
                        2'd2:    r_asm[7:0]   <= i_mem_rdata;
                        default: begin
                            if (r_owner == c_OWNER_LD) begin
                                r_ld_data <= w_word;
                            end else begin
                                r_if_instr <= w_word;
                            end
                        end
                    endcase
                    r_beat <= r_beat + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_grant_valid) w_next_state = c_READ;
            c_READ:  if (r_beat == 2'd3) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        o_mem_addr = 32'd0;
        o_if_ack   = 1'b0;
        o_ld_ack   = 1'b0;
        o_busy     = 1'b0;
        case (r_state)
            c_READ: begin
                o_busy     = 1'b1;
                o_mem_addr = r_base + {30'd0, r_beat};
            end
            c_DONE: begin
                o_busy   = 1'b1;
                o_if_ack = (r_owner == c_OWNER_IF);
                o_ld_ack = (r_owner == c_OWNER_LD);
            end
            default: ;
        endcase
    end

    assign o_if_instr = r_if_instr;
    assign o_ld_data  = r_ld_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. The stimulus process
//            pushes the expected memory addresses and completions into
//            queues. A monitor process pops entries and compares them
//            whenever the DUT shows a read beat or an ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam logic c_IF = 1'b0;
    localparam logic c_LD = 1'b1;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_instr;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_ack;
    logic [31:0] ld_data;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        busy;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic [31:0] addr_q[$];
    exp_t        ack_q[$];

    int tests     = 0;
    int fails     = 0;
    int ack_count = 0;
    logic [31:0] hold_if = 32'd0;
    logic [31:0] hold_ld = 32'd0;

    mem_port_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_ack    (if_ack),
        .o_if_instr  (if_instr),
        .i_ld_req    (ld_req),
        .i_ld_addr   (ld_addr),
        .o_ld_ack    (ld_ack),
        .o_ld_data   (ld_data),
        .o_mem_addr  (mem_addr),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fixed words at 0x00 and 0x10, otherwise addr[7:0]^0x5A.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0:   return 8'h8C;
            32'h1:   return 8'h01;
            32'h2:   return 8'h00;
            32'h3:   return 8'h04;
            32'h10:  return 8'hDE;
            32'h11:  return 8'hAD;
            32'h12:  return 8'hBE;
            32'h13:  return 8'hEF;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign mem_rdata = mem_byte(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_txn(input logic port, input logic [31:0] addr, input logic [31:0] data);
        for (int b = 0; b < 4; b++) addr_q.push_back(addr + b);
        ack_q.push_back('{port: port, data: data});
    endtask

    // Wait until the monitor has seen `target` acks. Returns just after the
    // rising edge that ends the DONE cycle, so the state is IDLE.
    task automatic wait_acks(input int target);
        int budget;
        budget = 200;
        while (ack_count < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (ack_count < target) check("ack_timeout", ack_count, target);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        int   beats;
        logic prev_ack;
        exp_t e;
        beats    = 0;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                beats    = 0;
                prev_ack = 1'b0;
            end else begin
                if (prev_ack) begin
                    check("ack_one_cycle", {30'd0, if_ack, ld_ack}, 32'd0);
                    check("idle_after_done", {31'd0, busy}, 32'd0);
                end
                if (if_ack && ld_ack) check("both_acks", 32'd1, 32'd0);
                if (busy && !if_ack && !ld_ack) begin
                    if (addr_q.size() == 0) begin
                        check("unexpected_beat", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        check("mem_addr", mem_addr, addr_q.pop_front());
                    end
                    beats++;
                end else if (!busy) begin
                    check("idle_mem_addr", mem_addr, 32'd0);
                end
                if (if_ack || ld_ack) begin
                    ack_count++;
                    check("done_mem_addr", mem_addr, 32'd0);
                    check("beats_before_ack", beats, 4);
                    beats = 0;
                    if (ack_q.size() == 0) begin
                        check("unexpected_ack", {30'd0, if_ack, ld_ack}, 32'd0);
                    end else begin
                        e = ack_q.pop_front();
                        check("ack_port", {31'd0, ld_ack}, {31'd0, e.port});
                        if (e.port == c_LD) hold_ld = e.data;
                        else                hold_if = e.data;
                    end
                    check("if_instr", if_instr, hold_if);
                    check("ld_data", ld_data, hold_ld);
                end
                prev_ack = if_ack | ld_ack;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit found;
        int base;
        rst_n   = 1'b1;
        if_req  = 1'b0;
        ld_req  = 1'b0;
        if_addr = 32'd0;
        ld_addr = 32'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_if_ack",   {31'd0, if_ack}, 32'd0);
        check("rst_ld_ack",   {31'd0, ld_ack}, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_ld_data",  ld_data, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single fetch at address 0.
        push_txn(c_IF, 32'h0, 32'h8C01_0004);
        if_req = 1'b1;
        wait_acks(1);
        if_req = 1'b0;

        // Simultaneous requests: LD first, then IF.
        push_txn(c_LD, 32'h10, 32'hDEAD_BEEF);
        push_txn(c_IF, 32'h0,  32'h8C01_0004);
        if_addr = 32'h0;
        ld_addr = 32'h10;
        if_req  = 1'b1;
        ld_req  = 1'b1;
        wait_acks(2);
        ld_req = 1'b0;
        wait_acks(3);
        if_req = 1'b0;

        // Both held for four transactions: LD, IF, LD, IF.
        push_txn(c_LD, 32'h10, 32'hDEAD_BEEF);
        push_txn(c_IF, 32'h0,  32'h8C01_0004);
        push_txn(c_LD, 32'h10, 32'hDEAD_BEEF);
        push_txn(c_IF, 32'h0,  32'h8C01_0004);
        if_req = 1'b1;
        ld_req = 1'b1;
        wait_acks(7);
        if_req = 1'b0;
        ld_req = 1'b0;

        // Load that wraps past the top of the address space.
        push_txn(c_LD, 32'hFFFF_FFFE, 32'hA4A5_8C01);
        ld_addr = 32'hFFFF_FFFE;
        ld_req  = 1'b1;
        wait_acks(8);
        ld_req = 1'b0;

        // Changes to the fetch address during READ are ignored. A load pulse
        // that ends before the arbiter returns to IDLE is lost.
        push_txn(c_IF, 32'h0, 32'h8C01_0004);
        if_addr = 32'h0;
        if_req  = 1'b1;
        @(posedge clk);
        #1;
        if_addr = 32'h10;
        ld_addr = 32'h20;
        ld_req  = 1'b1;
        @(posedge clk);
        #1;
        ld_req = 1'b0;
        wait_acks(9);
        if_req  = 1'b0;
        if_addr = 32'h0;

        // Reset during beat 2 of a fetch.
        push_txn(c_IF, 32'h0, 32'h8C01_0004);
        if_req = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && mem_addr == 32'h2) begin
                found = 1'b1;
                break;
            end
        end
        check("beat2_reached", {31'd0, found}, 32'd1);
        #2;
        rst_n = 1'b0;
        addr_q.delete();
        ack_q.delete();
        hold_if = 32'd0;
        hold_ld = 32'd0;
        #1;
        check("abort_if_ack",   {31'd0, if_ack}, 32'd0);
        check("abort_if_instr", if_instr, 32'd0);
        check("abort_ld_data",  ld_data, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_busy",     {31'd0, busy}, 32'd0);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // A fetch after the reset completes normally.
        base = ack_count;
        push_txn(c_IF, 32'h0, 32'h8C01_0004);
        if_req = 1'b1;
        wait_acks(base + 1);
        if_req = 1'b0;

        // Quiet period: the monitor catches any stray beats or acks.
        repeat (10) @(posedge clk);
        check("addr_q_empty", addr_q.size(), 32'd0);
        check("ack_q_empty",  ack_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
